// File: rtl/display_scan_driver_if.sv
// Digit-code inputs and display-pin outputs of the scan driver.
// The upstream/board side uses master; the driver itself uses slave.
interface display_scan_driver_if;
  logic       EN;
  logic [3:0] dig6;
  logic [3:0] dig5;
  logic [3:0] dig4;
  logic [3:0] dig3;
  logic [3:0] dig2;
  logic [3:0] dig1;
  logic [5:0] dp_mask;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;
  logic       slot_start;

  modport master (
    output EN, dig6, dig5, dig4, dig3, dig2, dig1, dp_mask,
    input  seg, dp, an, slot_start
  );

  modport slave (
    input  EN, dig6, dig5, dig4, dig3, dig2, dig1, dp_mask,
    output seg, dp, an, slot_start
  );
endinterface

// File: rtl/display_scan_driver.sv
// Time-multiplexed 7-segment scan driver: one digit captured per slot, anodes dark for the
// first BLANK_CYC cycles of each slot to suppress ghosting, pin polarity set by ACTIVE_LOW.
module display_scan_driver #(
  parameter int unsigned NUM_DIG    = 6,
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned BLANK_CYC  = 500,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input logic                  CLK,
  input logic                  RST,
  display_scan_driver_if.slave bus
);

  localparam int unsigned CntW = $clog2(SCAN_DIV);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [3:0]      code_q, code_d;
  logic            cur_dp_q, cur_dp_d;
  logic            wrap;

  logic [6:0] seg_l;
  logic [5:0] an_l;
  logic       dp_l;

  logic [6:0] seg_q;
  logic [5:0] an_q;
  logic       dp_q;
  logic       slot_start_q;

  logic [3:0] digs [6];

  assign digs[0] = bus.dig1;
  assign digs[1] = bus.dig2;
  assign digs[2] = bus.dig3;
  assign digs[3] = bus.dig4;
  assign digs[4] = bus.dig5;
  assign digs[5] = bus.dig6;

  // Logical (active-high) segment pattern, gfedcba; B..F are dark.
  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h40;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  always_comb begin
    wrap     = (cnt_q == CntW'(SCAN_DIV - 1));
    cnt_d    = wrap ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    code_d   = code_q;
    cur_dp_d = cur_dp_q;
    if (wrap) begin
      idx_d    = (idx_q == 3'(NUM_DIG - 1)) ? '0 : idx_q + 1'b1;
      // Capture once per slot so mid-slot input changes cannot tear the digit.
      code_d   = digs[idx_d];
      cur_dp_d = bus.dp_mask[idx_d];
    end
  end

  // Outputs are computed from post-update state so they line up with the new cnt/idx.
  always_comb begin
    an_l = '0;
    if (bus.EN && (cnt_d >= CntW'(BLANK_CYC))) begin
      an_l = 6'b1 << idx_d;
    end
    seg_l = decode(code_d);
    dp_l  = cur_dp_d && (an_l != '0);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      code_q       <= 4'hF;
      cur_dp_q     <= 1'b0;
      seg_q        <= {7{ACTIVE_LOW}};
      an_q         <= {6{ACTIVE_LOW}};
      dp_q         <= ACTIVE_LOW;
      slot_start_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      code_q       <= code_d;
      cur_dp_q     <= cur_dp_d;
      seg_q        <= seg_l ^ {7{ACTIVE_LOW}};
      an_q         <= an_l ^ {6{ACTIVE_LOW}};
      dp_q         <= dp_l ^ ACTIVE_LOW;
      slot_start_q <= (cnt_d == '0);
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.dp         = dp_q;
  assign bus.slot_start = slot_start_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// Scoreboard bench for display_scan_driver: a time-based reference model queues the expected
// outputs each edge, a monitor compares them for an active-high and an active-low instance.
module tb_display_scan_driver;

  localparam int unsigned NumDig   = 6;
  localparam int unsigned ScanDiv  = 8;
  localparam int unsigned BlankCyc = 2;

  typedef struct packed {
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ss;
  } exp_t;

  logic       CLK;
  logic       RST;
  logic       en;
  logic [3:0] dig [6];
  logic [5:0] dp_mask;

  int total = 0;
  int bad   = 0;
  int t     = 0;

  exp_t q[$];

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h40, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

  display_scan_driver_if bus0 ();
  display_scan_driver_if bus1 ();

  assign bus0.EN      = en;
  assign bus0.dp_mask = dp_mask;
  assign bus0.dig1    = dig[0];
  assign bus0.dig2    = dig[1];
  assign bus0.dig3    = dig[2];
  assign bus0.dig4    = dig[3];
  assign bus0.dig5    = dig[4];
  assign bus0.dig6    = dig[5];
  assign bus1.EN      = en;
  assign bus1.dp_mask = dp_mask;
  assign bus1.dig1    = dig[0];
  assign bus1.dig2    = dig[1];
  assign bus1.dig3    = dig[2];
  assign bus1.dig4    = dig[3];
  assign bus1.dig5    = dig[4];
  assign bus1.dig6    = dig[5];

  display_scan_driver #(
    .NUM_DIG   (NumDig),
    .SCAN_DIV  (ScanDiv),
    .BLANK_CYC (BlankCyc),
    .ACTIVE_LOW(1'b0)
  ) u_dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus0.slave)
  );

  display_scan_driver #(
    .NUM_DIG   (NumDig),
    .SCAN_DIV  (ScanDiv),
    .BLANK_CYC (BlankCyc),
    .ACTIVE_LOW(1'b1)
  ) u_dut_n (
    .CLK(CLK),
    .RST(RST),
    .bus(bus1.slave)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input logic [5:0] an, input logic [6:0] seg,
                       input logic dp, input logic ss, input exp_t e);
    total++;
    if ({an, seg, dp, ss} !== {e.an, e.seg, e.dp, e.ss}) begin
      bad++;
      $display("FAIL %s @%0t: got an=%b seg=%h dp=%b ss=%b, want an=%b seg=%h dp=%b ss=%b",
               name, $time, an, seg, dp, ss, e.an, e.seg, e.dp, e.ss);
    end
  endtask

  // Compare both instances against a logical (active-high) expectation.
  task automatic check_both(input string name, input exp_t e);
    exp_t ei;
    ei = '{an: e.an ^ 6'h3F, seg: e.seg ^ 7'h7F, dp: ~e.dp, ss: e.ss};
    check({name, "/hi"}, bus0.an, bus0.seg, bus0.dp, bus0.slot_start, e);
    check({name, "/lo"}, bus1.an, bus1.seg, bus1.dp, bus1.slot_start, ei);
  endtask

  task automatic dchk(input string name, input logic [5:0] an, input logic [6:0] seg,
                      input logic dp, input logic ss);
    exp_t e;
    e = '{an: an, seg: seg, dp: dp, ss: ss};
    check_both(name, e);
  endtask

  // Reference model: position in the scan derived from edges elapsed since reset release.
  initial begin
    int         m_t;
    logic [3:0] m_code;
    logic       m_dp;
    int         cnt;
    int         slot;
    exp_t       e;
    m_t    = 0;
    m_code = 4'hF;
    m_dp   = 1'b0;
    forever begin
      @(posedge CLK);
      if (RST) begin
        m_t    = 0;
        m_code = 4'hF;
        m_dp   = 1'b0;
        e      = '0;
      end else begin
        m_t++;
        cnt  = m_t % ScanDiv;
        slot = (m_t / ScanDiv) % NumDig;
        if (cnt == 0) begin
          m_code = dig[slot];
          m_dp   = dp_mask[slot];
        end
        e.an  = (en && cnt >= BlankCyc) ? (6'b1 << slot) : 6'b0;
        e.seg = seg_tab[m_code];
        e.dp  = m_dp && (e.an != 6'b0);
        e.ss  = (cnt == 0);
      end
      q.push_back(e);
    end
  end

  // Monitor: every cycle presents an output; reset held high overrides the queued value.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (RST) e = '0;
        check_both("scan", e);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
    t++;
  endtask

  task automatic adv_to(input int target);
    while (t < target) tick();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST     = 1'b1;
    en      = 1'b1;
    dp_mask = 6'b0;
    dig     = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
    repeat (3) @(posedge CLK);
    #2;
    dchk("reset", 6'b0, 7'h00, 1'b0, 1'b0);
    RST = 1'b0;
    t   = 0;

    adv_to(3);   dchk("poweron_blank", 6'b000001, 7'h00, 1'b0, 1'b0);
    adv_to(8);   dchk("slot1_start", 6'b000000, 7'h5B, 1'b0, 1'b1);
    adv_to(11);  dchk("slot1_lit", 6'b000010, 7'h5B, 1'b0, 1'b0);
    adv_to(45);  dchk("slot5_lit", 6'b100000, 7'h7D, 1'b0, 1'b0);
    adv_to(50);  dchk("slot0_lit", 6'b000001, 7'h06, 1'b0, 1'b0);

    dig = '{4'd8, 4'd8, 4'd8, 4'hF, 4'd8, 4'd8};
    adv_to(66);  dchk("eight_slot2", 6'b000100, 7'h7F, 1'b0, 1'b0);
    adv_to(75);  dchk("blank_slot3", 6'b001000, 7'h00, 1'b0, 1'b0);

    adv_to(80);  dig[0] = 4'd3;
    adv_to(100); dchk("tear_before", 6'b000001, 7'h4F, 1'b0, 1'b0);
    dig[0] = 4'd7;
    adv_to(103); dchk("tear_hold", 6'b000001, 7'h4F, 1'b0, 1'b0);
    adv_to(107); dchk("tear_next", 6'b000010, 7'h7F, 1'b0, 1'b0);
    adv_to(146); dchk("tear_new", 6'b000001, 7'h07, 1'b0, 1'b0);

    dp_mask = 6'h3F;
    adv_to(150); en = 1'b0;
    adv_to(151); dchk("en_low_off", 6'b000000, 7'h07, 1'b0, 1'b0);
    adv_to(163); dchk("en_low_mid", 6'b000000, 7'h7F, 1'b0, 1'b0);
    adv_to(170); en = 1'b1;
    adv_to(171); dchk("en_resume", 6'b001000, 7'h00, 1'b1, 1'b0);
    adv_to(176); dchk("en_phase", 6'b000000, 7'h7F, 1'b0, 1'b1);

    adv_to(180);
    dp_mask = 6'b000100;
    dig[2]  = 4'hA;
    adv_to(209); dchk("dash_blank", 6'b000000, 7'h40, 1'b0, 1'b0);
    adv_to(210); dchk("dash_dp", 6'b000100, 7'h40, 1'b1, 1'b0);
    adv_to(219); dchk("dash_after", 6'b001000, 7'h00, 1'b0, 1'b0);

    adv_to(269); dchk("pre_reset", 6'b001000, 7'h00, 1'b0, 1'b0);
    RST = 1'b1;
    #1;
    dchk("async_reset", 6'b000000, 7'h00, 1'b0, 1'b0);
    repeat (3) tick();
    RST = 1'b0;
    t   = 0;
    adv_to(3);   dchk("restart_blank", 6'b000001, 7'h00, 1'b0, 1'b0);
    adv_to(8);   dchk("restart_wrap", 6'b000000, 7'h7F, 1'b0, 1'b1);
    adv_to(20);

    @(negedge CLK);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
